// File: rtl/full_adder_pkg.sv
// Shared definitions for the full_adder slice: width limit, result type and a
// golden reference function for benches.
package full_adder_pkg;

    localparam int FA_MAX_WIDTH = 64;

    // Widest possible exact result: carry bit on top of FA_MAX_WIDTH sum bits.
    typedef logic [FA_MAX_WIDTH:0] fa_result_t;

    function automatic fa_result_t fa_ref(
        input logic [FA_MAX_WIDTH-1:0] a,
        input logic [FA_MAX_WIDTH-1:0] b,
        input logic                    cin
    );
        fa_result_t r;
        r = {1'b0, a} + {1'b0, b} + {{FA_MAX_WIDTH{1'b0}}, cin};
        return r;
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full-adder cell; chained by full_adder to form the ripple.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder: {CARRY,SUM} = A + B + C_IN, 1-cycle latency.
// Optional macro FULL_ADDER_OVERFLOW_EN adds a registered signed-overflow output OVF.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_IN,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY,
`ifdef FULL_ADDER_OVERFLOW_EN
    output logic             OVF,
`endif
    output logic             out_valid
);

    // Handshake: in_valid qualifies A/B/C_IN for one cycle; there is no ready,
    // so out_valid pulses exactly one cycle later and every result must be taken.

    logic [WIDTH-1:0] w_sum;
    logic             w_carry_msb;
    logic             w_carry_into_msb;

    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_valid;

    // Each bit cell keeps its own carry nets so the ripple is a clean chain.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic w_cin;
        logic w_cout;

        if (gi == 0) begin : g_first
            assign w_cin = C_IN;
        end else begin : g_rest
            assign w_cin = g_bit[gi-1].w_cout;
        end

        full_adder_bit u_bit (
            .a    (A[gi]),
            .b    (B[gi]),
            .cin  (w_cin),
            .s    (w_sum[gi]),
            .cout (w_cout)
        );
    end

    assign w_carry_msb      = g_bit[WIDTH-1].w_cout;
    assign w_carry_into_msb = g_bit[WIDTH-1].w_cin;

    // Operands are only sampled under in_valid, so X on idle inputs never reaches a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum   <= w_sum;
                r_carry <= w_carry_msb;
            end
        end
    end

    assign SUM       = r_sum;
    assign CARRY     = r_carry;
    assign out_valid = r_valid;

`ifdef FULL_ADDER_OVERFLOW_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_carry_msb ^ w_carry_into_msb;
        end
    end

    assign OVF = r_ovf;
`else
    logic w_unused_carry;
    assign w_unused_carry = w_carry_into_msb;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH 1, 8 and 16; checks OVF only when
// FULL_ADDER_OVERFLOW_EN is defined.
module tb_full_adder;
    import full_adder_pkg::*;

`ifdef FULL_ADDER_OVERFLOW_EN
    localparam bit HAS_OVF = 1'b1;
`else
    localparam bit HAS_OVF = 1'b0;
`endif
    localparam int EW = 18;  // {ovf, carry, sum[15:0]}

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        v1, a1, b1, c1, s1, cy1, ov1, ovf1;
    logic        v8, c8, cy8, ov8, ovf8;
    logic [7:0]  a8, b8, s8;
    logic        v16, c16, cy16, ov16, ovf16;
    logic [15:0] a16, b16, s16;

    logic [EW-1:0] q1[$], q8[$], q16[$];
    logic [EW-1:0] last1, last8, last16;
    logic          eov1, eov8, eov16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .A(a1), .B(b1), .C_IN(c1),
        .SUM(s1), .CARRY(cy1),
`ifdef FULL_ADDER_OVERFLOW_EN
        .OVF(ovf1),
`endif
        .out_valid(ov1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .A(a8), .B(b8), .C_IN(c8),
        .SUM(s8), .CARRY(cy8),
`ifdef FULL_ADDER_OVERFLOW_EN
        .OVF(ovf8),
`endif
        .out_valid(ov8)
    );

    full_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .A(a16), .B(b16), .C_IN(c16),
        .SUM(s16), .CARRY(cy16),
`ifdef FULL_ADDER_OVERFLOW_EN
        .OVF(ovf16),
`endif
        .out_valid(ov16)
    );

`ifndef FULL_ADDER_OVERFLOW_EN
    assign ovf1  = 1'b0;
    assign ovf8  = 1'b0;
    assign ovf16 = 1'b0;
`endif

    function automatic logic [EW-1:0] pk(input logic o, input logic cy, input logic [15:0] s);
        return {o & HAS_OVF, cy, s};
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected out_valid is in_valid seen at the previous active edge.
    always @(posedge clk) begin
        eov1  = rst_n & v1;
        eov8  = rst_n & v8;
        eov16 = rst_n & v16;
    end

    // Monitors: pop on out_valid, otherwise require the last result to be held.
    always @(negedge clk) begin
        logic [EW-1:0] act, e;
        act = {ovf1, cy1, 15'b0, s1};
        if (!rst_n) begin
            check("w1_reset", {ov1, act}, '0);
            last1 = '0;
        end else begin
            check("w1_out_valid", ov1, eov1);
            if (ov1) begin
                if (q1.size() == 0) check("w1_unexpected_result", 1'b1, 1'b0);
                else begin
                    e = q1.pop_front();
                    check("w1_result", act, e);
                    last1 = e;
                end
            end else check("w1_hold", act, last1);
        end
    end

    always @(negedge clk) begin
        logic [EW-1:0] act, e;
        act = {ovf8, cy8, 8'b0, s8};
        if (!rst_n) begin
            check("w8_reset", {ov8, act}, '0);
            last8 = '0;
        end else begin
            check("w8_out_valid", ov8, eov8);
            if (ov8) begin
                if (q8.size() == 0) check("w8_unexpected_result", 1'b1, 1'b0);
                else begin
                    e = q8.pop_front();
                    check("w8_result", act, e);
                    last8 = e;
                end
            end else check("w8_hold", act, last8);
        end
    end

    always @(negedge clk) begin
        logic [EW-1:0] act, e;
        act = {ovf16, cy16, s16};
        if (!rst_n) begin
            check("w16_reset", {ov16, act}, '0);
            last16 = '0;
        end else begin
            check("w16_out_valid", ov16, eov16);
            if (ov16) begin
                if (q16.size() == 0) check("w16_unexpected_result", 1'b1, 1'b0);
                else begin
                    e = q16.pop_front();
                    check("w16_result", act, e);
                    last16 = e;
                end
            end else check("w16_hold", act, last16);
        end
    end

    // Drive one cycle on the selected DUT; an expected entry is queued only when valid.
    task automatic drive(input int sel, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic [EW-1:0] exp);
        case (sel)
            1: begin v1 = v; a1 = a[0]; b1 = b[0]; c1 = c; if (v) q1.push_back(exp); end
            8: begin v8 = v; a8 = a[7:0]; b8 = b[7:0]; c8 = c; if (v) q8.push_back(exp); end
            default: begin v16 = v; a16 = a; b16 = b; c16 = c; if (v) q16.push_back(exp); end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic drive16_model(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] s17;
        logic        o;
        s17 = {1'b0, a} + {1'b0, b} + {16'b0, c};
        o   = (a[15] == b[15]) && (s17[15] != a[15]);
        drive(16, v, a, b, c, pk(o, s17[16], s17[15:0]));
    endtask

    // {ovf, carry, sum} for {A,B,C_IN} = 000..111
    logic [2:0] tab1 [8] = '{3'b000, 3'b101, 3'b001, 3'b010, 3'b001, 3'b010, 3'b110, 3'b011};

    initial begin
        v1 = 0; a1 = 0; b1 = 0; c1 = 0;
        v8 = 0; a8 = 0; b8 = 0; c8 = 0;
        v16 = 0; a16 = 0; b16 = 0; c16 = 0;
        last1 = '0; last8 = '0; last16 = '0;
        eov1 = 0; eov8 = 0; eov16 = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        a8 = 'x; b8 = 'x; c8 = 'x;
        a16 = 'x; b16 = 'x; c16 = 'x;

        check("fa_ref_wrap", fa_ref('1, 64'h1, 1'b0), {1'b1, 64'h0});
        check("fa_ref_small", fa_ref(64'h7F, 64'h01, 1'b1), 65'h81);

        // WIDTH=1 exhaustive, back to back
        for (int i = 0; i < 8; i++) begin
            logic [2:0] t, v;
            v = 3'(i);
            t = tab1[i];
            drive(1, 1'b1, {15'b0, v[2]}, {15'b0, v[1]}, v[0], pk(t[2], t[1], {15'b0, t[0]}));
        end

        // Hold: register result 10, then idle with zero inputs
        drive(1, 1'b1, 16'h1, 16'h0, 1'b1, pk(1'b0, 1'b1, 16'h0));
        repeat (3) drive(1, 1'b0, 16'h0, 16'h0, 1'b0, '0);

        // Reset mid-stream: 111 captured, then reset pulled low between edges
        v1 = 1; a1 = 1; b1 = 1; c1 = 1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        q1.delete();
        #1;
        check("async_reset_w1", {ov1, cy1, s1}, 3'b000);
        v1 = 0; a1 = 0; b1 = 0; c1 = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 1'b1, 16'h1, 16'h1, 1'b0, pk(1'b1, 1'b1, 16'h0));
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0, '0);

        // WIDTH=8 directed boundaries, hand-computed
        drive(8, 1'b1, 16'hFF, 16'h00, 1'b1, pk(1'b0, 1'b1, 16'h00));
        drive(8, 1'b1, 16'h7F, 16'h01, 1'b0, pk(1'b1, 1'b0, 16'h80));
        drive(8, 1'b1, 16'h80, 16'h80, 1'b0, pk(1'b1, 1'b1, 16'h00));
        drive(8, 1'b1, 16'hFF, 16'hFF, 1'b1, pk(1'b0, 1'b1, 16'hFF));
        drive(8, 1'b1, 16'h00, 16'h00, 1'b0, pk(1'b0, 1'b0, 16'h00));
        drive(8, 1'b1, 16'h12, 16'h34, 1'b1, pk(1'b0, 1'b0, 16'h47));
        drive(8, 1'b0, 16'hxx, 16'hxx, 1'bx, '0);
        drive(8, 1'b0, 16'hxx, 16'hxx, 1'bx, '0);

        // WIDTH=16: directed corners, then random back-to-back, then random gaps
        drive(16, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, pk(1'b0, 1'b1, 16'hFFFF));
        drive(16, 1'b1, 16'h8000, 16'hFFFF, 1'b0, pk(1'b1, 1'b1, 16'h7FFF));
        for (int k = 0; k < 1000; k++)
            drive16_model(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 1) == 1)
                drive16_model(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            else
                drive(16, 1'b0, 'x, 'x, 1'bx, '0);
        end
        drive(16, 1'b0, 'x, 'x, 1'bx, '0);

        repeat (3) @(posedge clk);
        #1;
        check("drain_w1", 65'(q1.size()), 65'd0);
        check("drain_w8", 65'(q8.size()), 65'd0);
        check("drain_w16", 65'(q16.size()), 65'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered N-bit ripple-carry adder: SUM/CARRY = A + B + C_IN.
- Default WIDTH=1 gives the classic 1-bit full-adder truth table, with outputs registered one cycle after the inputs.
- Used as an arithmetic leaf cell in datapaths; chained bit cells form the ripple.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..64).

Ports:
- clk      input   1      rising-edge clock
- rst_n    input   1      asynchronous active-low reset
- in_valid input   1      A/B/C_IN qualify this cycle
- A        input   WIDTH  operand A, unsigned
- B        input   WIDTH  operand B, unsigned
- C_IN     input   1      carry in
- SUM      output  WIDTH  registered sum bits
- CARRY    output  1      registered carry out (MSB cell carry)
- out_valid output 1      SUM/CARRY hold a new result

Interface:
- One clock, clk.
- Reset rst_n is asynchronous and active-low.
- All outputs are driven from flops.

Behaviour:
- Reset: while rst_n=0, SUM=0, CARRY=0, out_valid=0, immediately (no clock needed).
- Reset release is synchronous-safe. The first capture happens on the first rising clk edge with rst_n=1.
- Compute {CARRY,SUM} = A + B + C_IN, a (WIDTH+1)-bit exact result with no truncation.
- Bit i: s_i = a_i ^ b_i ^ c_i; c_{i+1} = a_i&b_i | c_i&(a_i^b_i); c_0 = C_IN; CARRY = c_WIDTH.
- Latency is exactly 1 cycle. The cycle with in_valid=1 at edge k gives SUM/CARRY valid and out_valid=1 after edge k.
- in_valid=0 at an edge: SUM/CARRY hold their previous value; out_valid goes to 0.
- Back-to-back in_valid=1 gives throughput of 1 result/cycle.
- No back-pressure; the downstream block must accept every result.
- Boundary cases:
  - All ones plus C_IN=1 gives SUM = all ones, CARRY=1.
  - All zeros gives SUM=0, CARRY=0.
  - Wrap-around is expressed only through CARRY.
- Reset asserted mid-stream: the in-flight result is discarded and outputs clear asynchronously.
- X on inputs while in_valid=0 must not propagate to the outputs.

Optional Feature:
- Macro FULL_ADDER_OVERFLOW_EN.
- When defined, an extra output port OVF (1 bit, registered, same timing as SUM) is added.
- OVF = c_WIDTH ^ c_{WIDTH-1}, i.e. signed two's-complement overflow. For WIDTH=1, OVF = CARRY ^ C_IN.
- OVF resets to 0 and holds when in_valid=0.
- When the macro is undefined, the port and its logic do not exist. The remaining behaviour is identical.

Decomposition:
- Shared package full_adder_pkg:
  - constant FA_MAX_WIDTH=64
  - typedef for the (WIDTH+1)-bit result
  - function fa_ref(a,b,cin) returning the golden sum, for use by benches
- One natural sub-module: full_adder_bit.
  - Purely combinational 1-bit cell: inputs a, b, cin; outputs s, cout.
  - Instantiated WIDTH times in a generate loop to form the ripple.
- The top level holds the output registers, the valid pipeline and the optional OVF logic.

Test Plan:
- WIDTH=1, exhaustive {A,B,C_IN}=000..111, one per cycle with in_valid=1. Expected {CARRY,SUM}, one cycle later, in order: 00,01,01,10,01,10,10,11.
- Reset: drive 111 and clock once, then pull rst_n low between edges. Required: SUM=0, CARRY=0, out_valid=0 before the next edge.
- Hold: result 10 registered, then in_valid=0 with A=B=C_IN=0. Required: SUM/CARRY stay 10, out_valid=0.
- WIDTH=8, A=8'hFF, B=8'h00, C_IN=1. Required: SUM=8'h00, CARRY=1; with FULL_ADDER_OVERFLOW_EN, OVF=0.
- WIDTH=8 with FULL_ADDER_OVERFLOW_EN, A=8'h7F, B=8'h01, C_IN=0. Required: SUM=8'h80, CARRY=0, OVF=1.
- WIDTH=16: 1000 random back-to-back vectors checked against fa_ref with 1-cycle latency. out_valid must track in_valid delayed by 1.
